branch_switch_pc_ctrl: RTL and testbench
========================================

// Module: branch_switch_pc_ctrl
// PURPOSE
//  Execution-side consumer of the branch-switch configuration reader outputs.
//  Holds the per-thread branch-switch config memory and the per-thread PC, pc_max and pc_loop registers.
//  Each enabled cycle, for the selected thread it:
//    - emits the switch config word at that thread's current PC;
//    - advances the PC, looping to pc_loop after pc_max.
//  Sits between the branch-switch conf reader and the branch network mux select.
// PARAMETERS
//  THREAD_BITS  3  thread-id width; NUM_THREADS = 2**THREAD_BITS
//  PC_BITS      1  PC / instruction-address width; per-thread memory depth = 2**PC_BITS
//  CONF_BITS    2  switch config word width
// PORTS
//  clk            in   1          clock; all logic on posedge
//  rst            in   1          synchronous, active-high reset
//  pc_max         in   PC_BITS    last PC before loop-back (config side)
//  pc_max_we      in   1          write pc_max into pc_max_r[thread_id]
//  pc_loop        in   PC_BITS    loop-back target PC (config side)
//  pc_loop_we     in   1          write pc_loop into pc_loop_r[thread_id]
//  thread_id      in   THREAD_BITS  thread targeted by any config write
//  net_mem_we     in   1          write net_mem_data to mem[{thread_id,net_mem_waddr}]
//  net_mem_waddr  in   PC_BITS    config memory write address within thread
//  net_mem_data   in   CONF_BITS  config word to store
//  pc_restart     in   1          set all thread PCs to 0 (config kept)
//  en             in   1          issue one fetch for thread_sel this cycle
//  thread_sel     in   THREAD_BITS  thread being issued
//  conf_out       out  CONF_BITS  switch config word fetched (registered)
//  conf_valid     out  1          conf_out / conf_thread / wrap valid this cycle
//  conf_thread    out  THREAD_BITS  thread that conf_out belongs to
//  wrap           out  1          the fetch consumed the pc_max entry (PC looped back)
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//    - every pc_r, pc_max_r, pc_loop_r and every mem entry <= 0;
//    - conf_out, conf_valid, conf_thread, wrap <= 0.
//    - rst has priority over every other input. Reset mid-run drops any in-flight fetch:
//      conf_valid is 0 on the cycle after the reset edge.
//  Config writes:
//    - pc_max_we, pc_loop_we and net_mem_we are independent and may all fire in one cycle.
//    - Each write lands at the posedge and is visible to a fetch from the next cycle on.
//  Fetch (en=1, t=thread_sel), latency 1 cycle:
//    - conf_out    <= mem[{t,pc_r[t]}]
//    - conf_valid  <= 1
//    - conf_thread <= t
//    - wrap        <= (pc_r[t]==pc_max_r[t])
//    - pc_r[t]     <= (pc_r[t]==pc_max_r[t]) ? pc_loop_r[t] : pc_r[t]+1
//  en=0: conf_valid <= 0, wrap <= 0; conf_out and conf_thread hold their values; no PC moves.
//  PC arithmetic:
//    - pc_r+1 is modulo 2**PC_BITS, with no overflow flag.
//    - Loop-back uses an equality compare only. If pc_max is lowered below the current PC,
//      the PC counts up and wraps modulo before matching.
//  Simultaneous events:
//    - net_mem_we on the address being fetched in the same cycle: the fetch returns the OLD word
//      (read-before-write).
//    - pc_max_we / pc_loop_we for thread t while fetching t: the PC update uses the OLD
//      pc_max_r / pc_loop_r values.
//    - pc_restart together with en: the fetch uses the pre-restart PC, then every PC
//      (including t) <= 0; the restart wins.
//  No back-pressure: the consumer must accept conf_out every valid cycle.
// STRUCTURE
//  Shared package (branch network defs):
//    - CGRA_CONF_* opcode constants;
//    - THREAD_BITS / PC_BITS / CONF_BITS defaults;
//    - typedef for the {thread,pc} memory address.
//  Sub-module branch_switch_conf_mem:
//    - 2**(THREAD_BITS+PC_BITS) x CONF_BITS;
//    - 1 sync write port, 1 registered read-first port, synchronous clear on rst.
//  PC / pc_max / pc_loop register arrays and the next-PC logic stay in this module.
// TESTING (PC_BITS=2 unless stated)
//  1. After reset, en=1, thread_sel=5 -> next cycle conf_valid=1, conf_thread=5, conf_out=0, wrap=1
//     (pc_max=0), pc stays 0.
//  2. Thread 2 setup:
//     - load mem[2][0..3] = 1,2,3,0; pc_max=3, pc_loop=1;
//     - then 7 fetches of thread 2 -> conf_out = 1,2,3,0,2,3,0; wrap on the 4th and 7th outputs only.
//  3. Interleave threads 1 and 6 (thread 1: pc_max=1, pc_loop=0; thread 6: pc_max=2, pc_loop=2)
//     -> each thread's PC sequence is independent: 0,1,0,1 and 0,1,2,2.
//  4. Same cycle:
//     - net_mem_we to {3,pc_r[3]} = 2 (old word 1) with a fetch of thread 3 -> conf_out=1;
//     - a refetch after reaching that PC again -> 2.
//  5. pc_restart with en (thread 4 at pc 2) -> output = word at pc 2, all PCs 0;
//     next fetch of thread 4 returns mem[4][0].
//  6. rst asserted while en streams -> conf_valid=0 the next cycle; all config cleared,
//     so the next fetch returns 0 with wrap=1.

Source files
------------

// File: rtl/branch_switch_pc_ctrl_pkg.sv
// Shared branch-network definitions: config opcodes, default widths and the
// {thread,pc} address layout of the per-thread switch config memory.
package branch_switch_pc_ctrl_pkg;

  // Default geometry of the branch-switch config store.
  localparam int THREAD_BITS_DEF = 3;
  localparam int PC_BITS_DEF     = 1;
  localparam int CONF_BITS_DEF   = 2;

  // Switch config opcodes driven onto the branch network mux select.
  localparam logic [CONF_BITS_DEF-1:0] CGRA_CONF_NOP       = 2'd0;
  localparam logic [CONF_BITS_DEF-1:0] CGRA_CONF_PASS      = 2'd1;
  localparam logic [CONF_BITS_DEF-1:0] CGRA_CONF_TAKEN     = 2'd2;
  localparam logic [CONF_BITS_DEF-1:0] CGRA_CONF_NOT_TAKEN = 2'd3;

  // Config memory address for the default geometry: thread in the MSBs so
  // each thread owns one contiguous block of 2**PC_BITS words.
  typedef struct packed {
    logic [THREAD_BITS_DEF-1:0] thread;
    logic [PC_BITS_DEF-1:0]     pc;
  } conf_addr_t;

endpackage

// File: rtl/branch_switch_pc_ctrl_conf_mem.sv
// Per-thread branch-switch config memory: one synchronous write port and one
// registered read-first read port whose output holds while no read is issued.
module branch_switch_conf_mem #(
  parameter int ADDR_BITS = 4,
  parameter int CONF_BITS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [CONF_BITS-1:0] wdata,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [CONF_BITS-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [CONF_BITS-1:0] mem_q [DEPTH];
  logic [CONF_BITS-1:0] mem_d [DEPTH];
  logic [CONF_BITS-1:0] rdata_q;
  logic [CONF_BITS-1:0] rdata_d;

  // Next memory contents and read data; the read sees the pre-write word.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    mem_d   = mem_q;
    rdata_d = rdata_q;
    if (we) mem_d[waddr] = wdata;
    if (re) rdata_d = mem_q[raddr];
  end

  // Storage and read register, cleared synchronously.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the whole array is cleared because a fetch right after reset must return 0;
      //       this costs a reset path per bit and rules out a RAM macro.
      mem_q   <= '{default: '0};
      rdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      mem_q   <= mem_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/branch_switch_pc_ctrl.sv
// Execution-side branch-switch controller: per-thread PC / pc_max / pc_loop
// registers and config memory; each enabled cycle emits the selected thread's
// config word at its PC and advances that PC, looping after pc_max.
module branch_switch_pc_ctrl
  import branch_switch_pc_ctrl_pkg::*;
#(
  parameter int THREAD_BITS = THREAD_BITS_DEF,
  parameter int PC_BITS     = PC_BITS_DEF,
  parameter int CONF_BITS   = CONF_BITS_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PC_BITS-1:0]     pc_max,
  input  logic                   pc_max_we,
  input  logic [PC_BITS-1:0]     pc_loop,
  input  logic                   pc_loop_we,
  input  logic [THREAD_BITS-1:0] thread_id,
  input  logic                   net_mem_we,
  input  logic [PC_BITS-1:0]     net_mem_waddr,
  input  logic [CONF_BITS-1:0]   net_mem_data,
  input  logic                   pc_restart,
  input  logic                   en,
  input  logic [THREAD_BITS-1:0] thread_sel,
  output logic [CONF_BITS-1:0]   conf_out,
  output logic                   conf_valid,
  output logic [THREAD_BITS-1:0] conf_thread,
  output logic                   wrap
);

  localparam int NUM_THREADS = 1 << THREAD_BITS;
  localparam int ADDR_BITS   = THREAD_BITS + PC_BITS;

  logic [PC_BITS-1:0]     pc_q      [NUM_THREADS];
  logic [PC_BITS-1:0]     pc_d      [NUM_THREADS];
  logic [PC_BITS-1:0]     pc_max_q  [NUM_THREADS];
  logic [PC_BITS-1:0]     pc_max_d  [NUM_THREADS];
  logic [PC_BITS-1:0]     pc_loop_q [NUM_THREADS];
  logic [PC_BITS-1:0]     pc_loop_d [NUM_THREADS];
  logic                   conf_valid_q, conf_valid_d;
  logic                   wrap_q, wrap_d;
  logic [THREAD_BITS-1:0] conf_thread_q, conf_thread_d;

  logic [PC_BITS-1:0]     cur_pc;
  logic                   at_max;
  logic [ADDR_BITS-1:0]   rd_addr;
  logic [ADDR_BITS-1:0]   wr_addr;

  // Selected thread's current PC and loop-back test; all compare against pre-edge registers.
  always_comb begin
    cur_pc  = pc_q[thread_sel];
    at_max  = (cur_pc == pc_max_q[thread_sel]);
    rd_addr = {thread_sel, cur_pc};
    wr_addr = {thread_id, net_mem_waddr};
  end

  // Next PC / loop registers: fetch advance, config writes, then restart overrides PCs.
  always_comb begin
    pc_d      = pc_q;
    pc_max_d  = pc_max_q;
    pc_loop_d = pc_loop_q;
    if (en) begin
      pc_d[thread_sel] = at_max ? pc_loop_q[thread_sel] : cur_pc + PC_BITS'(1);
    end
    if (pc_restart) pc_d = '{default: '0};
    if (pc_max_we)  pc_max_d[thread_id]  = pc_max;
    if (pc_loop_we) pc_loop_d[thread_id] = pc_loop;
  end

  // Output side-band: valid/wrap pulse per fetch, thread tag holds when idle.
  always_comb begin
    conf_valid_d  = en;
    wrap_d        = en & at_max;
    conf_thread_d = en ? thread_sel : conf_thread_q;
  end

  // Register state with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= '{default: '0};
      pc_max_q      <= '{default: '0};
      pc_loop_q     <= '{default: '0};
      conf_valid_q  <= 1'b0;
      wrap_q        <= 1'b0;
      conf_thread_q <= '0;
    end else begin
      pc_q          <= pc_d;
      pc_max_q      <= pc_max_d;
      pc_loop_q     <= pc_loop_d;
      conf_valid_q  <= conf_valid_d;
      wrap_q        <= wrap_d;
      conf_thread_q <= conf_thread_d;
    end
  end

  branch_switch_conf_mem #(
    .ADDR_BITS(ADDR_BITS),
    .CONF_BITS(CONF_BITS)
  ) u_conf_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (net_mem_we),
    .waddr (wr_addr),
    .wdata (net_mem_data),
    .re    (en),
    .raddr (rd_addr),
    .rdata (conf_out)
  );

  assign conf_valid  = conf_valid_q;
  assign wrap        = wrap_q;
  assign conf_thread = conf_thread_q;

endmodule

// File: tb/tb_branch_switch_pc_ctrl.sv
// Self-checking bench for branch_switch_pc_ctrl (THREAD_BITS=3, PC_BITS=2, CONF_BITS=2):
// directed scenarios with literal expectations plus a per-cycle reference model.
module tb_branch_switch_pc_ctrl;

  localparam int TB = 3;
  localparam int PB = 2;
  localparam int CB = 2;
  localparam int NT = 8;
  localparam int NP = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [PB-1:0] pc_max;
  logic          pc_max_we;
  logic [PB-1:0] pc_loop;
  logic          pc_loop_we;
  logic [TB-1:0] thread_id;
  logic          net_mem_we;
  logic [PB-1:0] net_mem_waddr;
  logic [CB-1:0] net_mem_data;
  logic          pc_restart;
  logic          en;
  logic [TB-1:0] thread_sel;
  logic [CB-1:0] conf_out;
  logic          conf_valid;
  logic [TB-1:0] conf_thread;
  logic          wrap;

  int n_checks = 0;
  int n_fail   = 0;

  branch_switch_pc_ctrl #(
    .THREAD_BITS(TB),
    .PC_BITS    (PB),
    .CONF_BITS  (CB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_max       (pc_max),
    .pc_max_we    (pc_max_we),
    .pc_loop      (pc_loop),
    .pc_loop_we   (pc_loop_we),
    .thread_id    (thread_id),
    .net_mem_we   (net_mem_we),
    .net_mem_waddr(net_mem_waddr),
    .net_mem_data (net_mem_data),
    .pc_restart   (pc_restart),
    .en           (en),
    .thread_sel   (thread_sel),
    .conf_out     (conf_out),
    .conf_valid   (conf_valid),
    .conf_thread  (conf_thread),
    .wrap         (wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (behavioural, per-thread arrays) ----------------
  int m_mem  [NT][NP];
  int m_pc   [NT];
  int m_max  [NT];
  int m_loop [NT];
  int e_out = 0, e_thread = 0;
  bit e_valid = 0, e_wrap = 0;

  always @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < NT; t++) begin
        m_pc[t] <= 0; m_max[t] <= 0; m_loop[t] <= 0;
        for (int p = 0; p < NP; p++) m_mem[t][p] <= 0;
      end
      e_valid <= 0; e_wrap <= 0; e_out <= 0; e_thread <= 0;
    end else begin
      if (en) begin
        e_out    <= m_mem[thread_sel][m_pc[thread_sel]];
        e_thread <= int'(thread_sel);
        e_valid  <= 1;
        e_wrap   <= (m_pc[thread_sel] == m_max[thread_sel]);
        m_pc[thread_sel] <= (m_pc[thread_sel] == m_max[thread_sel])
                            ? m_loop[thread_sel] : (m_pc[thread_sel] + 1) % NP;
      end else begin
        e_valid <= 0;
        e_wrap  <= 0;
      end
      if (net_mem_we) m_mem[thread_id][net_mem_waddr] <= int'(net_mem_data);
      if (pc_max_we)  m_max[thread_id]  <= int'(pc_max);
      if (pc_loop_we) m_loop[thread_id] <= int'(pc_loop);
      if (pc_restart) for (int t = 0; t < NT; t++) m_pc[t] <= 0;
    end
  end

  // Compare process: outputs checked against the model on every falling edge.
  always @(negedge clk) begin
    check("cmp_valid", 32'(conf_valid), 32'(e_valid));
    check("cmp_wrap",  32'(wrap),       32'(e_wrap));
    if (e_valid) begin
      check("cmp_out",    32'(conf_out),    32'(e_out));
      check("cmp_thread", 32'(conf_thread), 32'(e_thread));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_mem(input int t, input int a, input int d);
    thread_id = TB'(t); net_mem_waddr = PB'(a); net_mem_data = CB'(d); net_mem_we = 1'b1;
    tick();
    net_mem_we = 1'b0;
  endtask

  task automatic wr_loop_regs(input int t, input int mx, input int lp);
    thread_id = TB'(t); pc_max = PB'(mx); pc_loop = PB'(lp);
    pc_max_we = 1'b1; pc_loop_we = 1'b1;
    tick();
    pc_max_we = 1'b0; pc_loop_we = 1'b0;
  endtask

  task automatic fetch(input int t);
    thread_sel = TB'(t); en = 1'b1;
    tick();
    en = 1'b0;
  endtask

  int exp2 [7];
  int wrp2 [7];
  int exp1 [4];
  int exp6 [4];

  initial begin
    exp2 = '{1, 2, 3, 0, 2, 3, 0};
    wrp2 = '{0, 0, 0, 1, 0, 0, 1};
    exp1 = '{0, 1, 0, 1};
    exp6 = '{0, 1, 2, 2};

    rst = 1'b1; en = 1'b0; thread_sel = '0; pc_restart = 1'b0;
    pc_max = '0; pc_max_we = 1'b0; pc_loop = '0; pc_loop_we = 1'b0;
    thread_id = '0; net_mem_we = 1'b0; net_mem_waddr = '0; net_mem_data = '0;
    tick(); tick();
    rst = 1'b0;
    check("reset_valid", 32'(conf_valid), 32'd0);
    check("reset_out",   32'(conf_out),   32'd0);
    check("reset_wrap",  32'(wrap),       32'd0);

    // 1. Fetch straight after reset: pc_max=0 so every fetch wraps at pc 0.
    fetch(5);
    check("t1_valid",  32'(conf_valid),  32'd1);
    check("t1_thread", 32'(conf_thread), 32'd5);
    check("t1_out",    32'(conf_out),    32'd0);
    check("t1_wrap",   32'(wrap),        32'd1);
    fetch(5);
    check("t1_wrap_again", 32'(wrap), 32'd1);
    tick();
    check("idle_valid", 32'(conf_valid), 32'd0);
    check("idle_hold_thread", 32'(conf_thread), 32'd5);

    // 2. Thread 2 program 1,2,3,0 with loop 3 -> 1.
    wr_mem(2, 0, 1); wr_mem(2, 1, 2); wr_mem(2, 2, 3); wr_mem(2, 3, 0);
    wr_loop_regs(2, 3, 1);
    for (int i = 0; i < 7; i++) begin
      fetch(2);
      check($sformatf("t2_out%0d", i),  32'(conf_out), 32'(exp2[i]));
      check($sformatf("t2_wrap%0d", i), 32'(wrap),     32'(wrp2[i]));
    end

    // 3. Interleaved threads 1 and 6; memory holds its own PC so outputs trace PCs.
    for (int p = 0; p < NP; p++) begin
      wr_mem(1, p, p);
      wr_mem(6, p, p);
    end
    wr_loop_regs(1, 1, 0);
    wr_loop_regs(6, 2, 2);
    for (int i = 0; i < 4; i++) begin
      fetch(1);
      check($sformatf("t3_th1_pc%0d", i), 32'(conf_out), 32'(exp1[i]));
      fetch(6);
      check($sformatf("t3_th6_pc%0d", i), 32'(conf_out), 32'(exp6[i]));
    end

    // 4. Read-before-write on the word being fetched.
    wr_mem(3, 0, 1); wr_mem(3, 1, 3);
    wr_loop_regs(3, 1, 0);
    thread_id = 3'd3; net_mem_waddr = 2'd0; net_mem_data = 2'd2; net_mem_we = 1'b1;
    fetch(3);
    net_mem_we = 1'b0;
    check("t4_old_word", 32'(conf_out), 32'd1);
    fetch(3);
    check("t4_pc1", 32'(conf_out), 32'd3);
    fetch(3);
    check("t4_new_word", 32'(conf_out), 32'd2);

    // 5. Restart together with a fetch of thread 4 at pc 2.
    wr_mem(4, 0, 3); wr_mem(4, 1, 1); wr_mem(4, 2, 2);
    wr_loop_regs(4, 3, 0);
    fetch(4); fetch(4);
    pc_restart = 1'b1;
    fetch(4);
    pc_restart = 1'b0;
    check("t5_restart_fetch", 32'(conf_out), 32'd2);
    fetch(4);
    check("t5_after_restart", 32'(conf_out), 32'd3);
    fetch(2);
    check("t5_other_thread_pc0", 32'(conf_out), 32'd1);

    // 6. Reset during a fetch stream clears everything.
    thread_sel = 3'd2; en = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    check("t6_valid_dropped", 32'(conf_valid), 32'd0);
    rst = 1'b0;
    tick();
    check("t6_first_after_rst", 32'(conf_out), 32'd0);
    check("t6_wrap_after_rst",  32'(wrap),     32'd1);
    en = 1'b0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
